encoder_1553_src: RTL and testbench

// - MIL-STD-1553B Manchester-II word encoder. It serialises one 16-bit word into a 20-bit-time frame:
//   3-bit-time sync, 16 data bits MSB first, then an odd parity bit.
// - Acts as the bus-controller stimulus source feeding the RT receive path in top_1553.
// - It also serves as a standalone transmitter.

---
 rtl/mil1553_pkg.sv | 33 +++
 rtl/enc_1553_tick.sv | 37 +++
 rtl/encoder_1553_src.sv | 74 +++++++
 tb/tb_encoder_1553_src.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mil1553_pkg.sv
// Shared MIL-STD-1553B constants and encoding helpers used by the Manchester word encoder.
package mil1553_pkg;

   localparam int CELLS_PER_WORD = 40;
   localparam int SYNC_CELLS     = 6;

   localparam logic [SYNC_CELLS-1:0] SYNC_CSW = 6'b111000;
   localparam logic [SYNC_CELLS-1:0] SYNC_DW  = 6'b000111;

   typedef enum logic {SYNC_KIND_DW = 1'b0, SYNC_KIND_CSW = 1'b1} sync_kind_e;

   function automatic logic [1:0] manchester(input logic b);
      return b ? 2'b10 : 2'b01;
   endfunction

   function automatic logic odd_parity(input logic [15:0] word);
      return ~^word;
   endfunction

   // Cell image of a whole word, MSB = c0, so the frame shifts out from bit 39.
   function automatic logic [CELLS_PER_WORD-1:0] build_frame(input sync_kind_e kind,
                                                             input logic [15:0] word);
      logic [CELLS_PER_WORD-1:0] f;
      f = '0;
      f[39:34] = (kind == SYNC_KIND_CSW) ? SYNC_CSW : SYNC_DW;
      for (int i = 0; i < 16; i++) begin
         f[33-2*i -: 2] = manchester(word[15-i]);
      end
      f[1:0] = manchester(odd_parity(word));
      return f;
   endfunction

endpackage

// File: rtl/enc_1553_tick.sv
// Half-bit-cell prescaler: emits a one-clock cell_adv strobe on the last clock of each cell.
module enc_1553_tick #(
   parameter int HALF_BIT_CLKS = 1
) (
   input  logic enc_clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic cell_adv_o
);

   localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CLKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign cell_adv_o = en_i & (cnt_q == LAST);

   // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i || cell_adv_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge enc_clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/encoder_1553_src.sv
// MIL-STD-1553B Manchester-II word encoder: sync, 16 data bits MSB first, odd parity; back-to-back capable.
module encoder_1553_src #(
   parameter int HALF_BIT_CLKS = 1
) (
   input  logic        enc_clk,
   input  logic        rst,
   input  logic [15:0] tx_dword,
   input  logic        tx_csw,
   input  logic        tx_dw,
   output logic        tx_busy,
   output logic        tx_data,
   output logic        tx_dval
);

   import mil1553_pkg::*;

   localparam logic [5:0] LAST_CELL = 6'(CELLS_PER_WORD - 1);

   logic                      busy_q, busy_d;
   logic [5:0]                cell_q, cell_d;
   logic [CELLS_PER_WORD-1:0] shreg_q, shreg_d;
   logic                      cell_adv;
   logic                      accept;
   sync_kind_e                kind;

   enc_1553_tick #(.HALF_BIT_CLKS(HALF_BIT_CLKS)) u_tick (
      .enc_clk    (enc_clk),
      .rst        (rst),
      .en_i       (busy_q),
      .clr_i      (accept),
      .cell_adv_o (cell_adv)
   );

   // A request is taken when idle or exactly on the final clock of c39.
   assign accept = (tx_csw | tx_dw) & (~busy_q | ((cell_q == LAST_CELL) & cell_adv));
   assign kind   = tx_csw ? SYNC_KIND_CSW : SYNC_KIND_DW;

   always_comb begin
      busy_d  = busy_q;
      cell_d  = cell_q;
      shreg_d = shreg_q;
      if (accept) begin
         busy_d  = 1'b1;
         cell_d  = '0;
         shreg_d = build_frame(kind, tx_dword);
      end else if (busy_q && cell_adv) begin
         if (cell_q == LAST_CELL) begin
            busy_d  = 1'b0;
            cell_d  = '0;
            shreg_d = '0;
         end else begin
            cell_d  = cell_q + 6'd1;
            shreg_d = {shreg_q[CELLS_PER_WORD-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge enc_clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         cell_q  <= '0;
         shreg_q <= '0;
      end else begin
         busy_q  <= busy_d;
         cell_q  <= cell_d;
         shreg_q <= shreg_d;
      end
   end

   assign tx_busy = busy_q;
   assign tx_dval = busy_q;
   assign tx_data = shreg_q[CELLS_PER_WORD-1];

endmodule

// File: tb/tb_encoder_1553_src.sv
// Directed bench for encoder_1553_src: one instance at HALF_BIT_CLKS=1, one at HALF_BIT_CLKS=4.
module tb_encoder_1553_src;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [15:0] a_dword = '0;
   logic        a_csw = 1'b0, a_dw = 1'b0;
   logic        a_busy, a_data, a_dval;

   logic [15:0] b_dword = '0;
   logic        b_csw = 1'b0, b_dw = 1'b0;
   logic        b_busy, b_data, b_dval;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   encoder_1553_src #(.HALF_BIT_CLKS(1)) dut1 (
      .enc_clk(clk), .rst(rst), .tx_dword(a_dword), .tx_csw(a_csw), .tx_dw(a_dw),
      .tx_busy(a_busy), .tx_data(a_data), .tx_dval(a_dval)
   );

   encoder_1553_src #(.HALF_BIT_CLKS(4)) dut4 (
      .enc_clk(clk), .rst(rst), .tx_dword(b_dword), .tx_csw(b_csw), .tx_dw(b_dw),
      .tx_busy(b_busy), .tx_data(b_data), .tx_dval(b_dval)
   );

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Request one frame on dut1 and record its 40 cells; the live word is scrambled after acceptance.
   task automatic run_frame1(input logic csw, input logic dw, input logic [15:0] w,
                             input int inject_at, output logic [39:0] bits,
                             output int dv, output int bz);
      @(posedge clk); #1;
      a_csw = csw; a_dw = dw; a_dword = w;
      @(posedge clk); #1;
      a_csw = 1'b0; a_dw = 1'b0; a_dword = 16'h0F0F;
      dv = 0; bz = 0; bits = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bits[39-i] = a_data;
         if (a_dval) dv++;
         if (a_busy) bz++;
         if (i == inject_at) begin
            a_dw = 1'b1; a_dword = 16'hFFFF;
         end else if (i == inject_at + 1) begin
            a_dw = 1'b0;
         end
      end
   endtask

   task automatic check_idle1(input string tag);
      @(negedge clk);
      check({tag, "_busy"}, 160'(a_busy), 160'(0));
      check({tag, "_dval"}, 160'(a_dval), 160'(0));
      check({tag, "_data"}, 160'(a_data), 160'(0));
   endtask

   task automatic frame_test(input string tag, input logic csw, input logic dw,
                             input logic [15:0] w, input int inject_at, input logic [39:0] exp);
      logic [39:0] bits;
      int dv, bz;
      run_frame1(csw, dw, w, inject_at, bits, dv, bz);
      check({tag, "_cells"}, 160'(bits), 160'(exp));
      check({tag, "_dval_cnt"}, 160'(dv), 160'(40));
      check({tag, "_busy_cnt"}, 160'(bz), 160'(40));
      check_idle1({tag, "_end"});
   endtask

   localparam logic [39:0] EXP_5555 = {6'b111000, {8{4'b0110}}, 2'b10};
   localparam logic [39:0] EXP_ABCD = {6'b000111, 8'b10011001, 8'b10011010,
                                       8'b10100101, 8'b10100110, 2'b10};
   localparam logic [39:0] EXP_0000 = {6'b000111, {16{2'b01}}, 2'b10};
   localparam logic [39:0] EXP_0001 = {6'b000111, {15{2'b01}}, 2'b10, 2'b01};
   localparam logic [39:0] EXP_1234 = {6'b111000, 8'b01010110, 8'b01011001,
                                       8'b01011010, 8'b01100101, 2'b01};
   localparam logic [39:0] EXP_FFFF = {6'b000111, {16{2'b10}}, 2'b10};
   localparam logic [39:0] EXP_AAAA = {6'b111000, {8{4'b1001}}, 2'b10};

   initial begin
      logic [39:0]  bits;
      logic [159:0] got4, exp4;
      int dv, gaps;

      // Reset state
      #22;
      check("rst_a_busy", 160'(a_busy), 160'(0));
      check("rst_a_dval", 160'(a_dval), 160'(0));
      check("rst_a_data", 160'(a_data), 160'(0));
      check("rst_b_busy", 160'(b_busy), 160'(0));
      check("rst_b_data", 160'(b_data), 160'(0));
      @(negedge clk);
      rst = 1'b0;

      frame_test("csw5555", 1'b1, 1'b0, 16'h5555, -1, EXP_5555);
      frame_test("dwABCD",  1'b0, 1'b1, 16'hABCD, -1, EXP_ABCD);
      frame_test("dw0000",  1'b0, 1'b1, 16'h0000, -1, EXP_0000);
      frame_test("dw0001",  1'b0, 1'b1, 16'h0001, -1, EXP_0001);
      // Both requests high -> CSW sync; an extra request at c20 must be ignored.
      frame_test("both1234", 1'b1, 1'b1, 16'h1234, 20, EXP_1234);

      // Continuous tx_dw: three contiguous frames, then release during the third.
      @(posedge clk); #1;
      a_dw = 1'b1; a_dword = 16'hFFFF;
      @(posedge clk);
      gaps = 0;
      for (int f = 0; f < 3; f++) begin
         bits = '0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bits[39-i] = a_data;
            if (!a_busy || !a_dval) gaps++;
            if (f == 2 && i == 0) a_dw = 1'b0;
         end
         check($sformatf("b2b_frame%0d", f), 160'(bits), 160'(EXP_FFFF));
      end
      check("b2b_gaps", 160'(gaps), 160'(0));
      check_idle1("b2b_end");

      // Reset asserted mid-frame at c15.
      @(posedge clk); #1;
      a_csw = 1'b1; a_dword = 16'h5555;
      @(posedge clk); #1;
      a_csw = 1'b0;
      repeat (16) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 160'(a_busy), 160'(0));
      check("midrst_dval", 160'(a_dval), 160'(0));
      check("midrst_data", 160'(a_data), 160'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle1("postrst_idle");
      frame_test("postrst5555", 1'b1, 1'b0, 16'h5555, -1, EXP_5555);

      // HALF_BIT_CLKS=4: every cell held for 4 clocks, 160 clocks total.
      for (int c = 0; c < 40; c++)
         for (int r = 0; r < 4; r++)
            exp4[159 - (4*c + r)] = EXP_AAAA[39-c];
      @(posedge clk); #1;
      b_csw = 1'b1; b_dword = 16'hAAAA;
      @(posedge clk); #1;
      b_csw = 1'b0; b_dword = 16'h0000;
      dv = 0; got4 = '0;
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         got4[159-k] = b_data;
         if (b_dval && b_busy) dv++;
      end
      check("h4_cells", got4, exp4);
      check("h4_dval_cnt", 160'(dv), 160'(160));
      @(negedge clk);
      check("h4_end_busy", 160'(b_busy), 160'(0));
      check("h4_end_data", 160'(b_data), 160'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
